// File: rtl/mem_arbiter_ctrl.sv
// Byte-wide RAM sequencer shared by fetch and load/store (MEM has priority); word read done 6 cycles after request, word store 5.
// No new access is accepted in a done cycle; stallreq holds the pipeline while any request is outstanding.
module mem_arbiter_ctrl #(
    parameter int RAM_ADDR_WIDTH = 17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [31:0]               if_addr,
    input  logic                      branch_flag_i,
    input  logic                      mem_req,
    input  logic                      mem_we,
    input  logic [1:0]                mem_len,
    input  logic [31:0]               mem_addr,
    input  logic [31:0]               mem_wdata,
    input  logic [7:0]                ram_din,
    output logic [RAM_ADDR_WIDTH-1:0] ram_a,
    output logic [7:0]                ram_dout,
    output logic                      ram_wr,
    output logic [31:0]               if_inst,
    output logic                      if_done,
    output logic [31:0]               mem_rdata,
    output logic                      mem_done,
    output logic                      stallreq
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt, num, mem_num;
    logic [31:0] base, wdata, cap, cap_nxt, addr_sum;
    logic [1:0]  lane;
    logic        start_if, start_mem, fin_if, fin_rd, fin_wr;
    logic        unused_addr_bits;

    assign addr_sum         = base + {29'd0, cnt};
    assign unused_addr_bits = ^addr_sum[31:RAM_ADDR_WIDTH];
    // Read data lags the address by one cycle, so count N captures byte N-1.
    assign lane             = 2'(cnt - 3'd1);
    assign mem_num          = (mem_len == 2'd0) ? 3'd1 : (mem_len == 2'd1) ? 3'd2 : 3'd4;
    assign stallreq         = (mem_req & ~mem_done) | (if_req & ~if_done & ~branch_flag_i);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cap_nxt   = cap;
        ram_a     = '0;
        ram_wr    = 1'b0;
        ram_dout  = 8'h00;
        start_if  = 1'b0;
        start_mem = 1'b0;
        fin_if    = 1'b0;
        fin_rd    = 1'b0;
        fin_wr    = 1'b0;
        case (state)
            IDLE: begin
                if (!(if_done || mem_done)) begin
                    if (mem_req) begin
                        start_mem = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = mem_we ? MEM_WR : MEM_RD;
                    end else if (if_req && !branch_flag_i) begin
                        start_if  = 1'b1;
                        cnt_nxt   = 3'd0;
                        state_nxt = IF_RD;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                if (cnt < num) begin
                    ram_a = addr_sum[RAM_ADDR_WIDTH-1:0];
                end
                if (cnt != 3'd0) begin
                    cap_nxt[{lane, 3'b000} +: 8] = ram_din;
                end
                cnt_nxt = cnt + 3'd1;
                if (cnt == num) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                    fin_if    = (state == IF_RD);
                    fin_rd    = (state == MEM_RD);
                end
                // A taken branch discards the fetch even on its final capture.
                if (state == IF_RD && branch_flag_i) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                    fin_if    = 1'b0;
                end
            end
            MEM_WR: begin
                if (cnt < num) begin
                    ram_a    = addr_sum[RAM_ADDR_WIDTH-1:0];
                    ram_dout = wdata[{cnt[1:0], 3'b000} +: 8];
                    ram_wr   = 1'b1;
                end
                cnt_nxt = cnt + 3'd1;
                if (cnt == num - 3'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 3'd0;
                    fin_wr    = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 3'd0;
            num       <= 3'd0;
            base      <= '0;
            wdata     <= '0;
            cap       <= '0;
            if_inst   <= '0;
            mem_rdata <= '0;
            if_done   <= 1'b0;
            mem_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            if_done  <= fin_if;
            mem_done <= fin_rd | fin_wr;
            if (start_mem) begin
                base  <= mem_addr;
                wdata <= mem_wdata;
                num   <= mem_num;
                cap   <= '0;
            end else if (start_if) begin
                base <= if_addr;
                num  <= 3'd4;
                cap  <= '0;
            end else begin
                cap <= cap_nxt;
            end
            if (fin_if) if_inst <= cap_nxt;
            if (fin_rd) mem_rdata <= cap_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Bench for mem_arbiter_ctrl: a byte RAM with one-cycle read latency plus a
// spec-level model (flat byte array, per-cycle expected address/strobe/done timing).
module tb_mem_arbiter_ctrl;

    localparam int AW       = 17;
    localparam int RAM_SIZE = 1 << AW;

    logic          clk, rst;
    logic          if_req, branch_flag_i, mem_req, mem_we;
    logic [31:0]   if_addr, mem_addr, mem_wdata;
    logic [1:0]    mem_len;
    logic [7:0]    ram_din, ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr, if_done, mem_done, stallreq;
    logic [31:0]   if_inst, mem_rdata;

    logic [7:0]    ram [0:RAM_SIZE-1];
    logic [7:0]    mdl [0:RAM_SIZE-1];
    logic [31:0]   last_inst, last_rdata;
    int            checks, failures;

    mem_arbiter_ctrl #(.RAM_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .branch_flag_i(branch_flag_i),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .ram_din(ram_din), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
        .if_inst(if_inst), .if_done(if_done),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .stallreq(stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr) ram[ram_a] <= ram_dout;
    end

    function automatic logic [AW-1:0] ma(input logic [31:0] a);
        return a[AW-1:0];
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a, input int n);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[8*k +: 8] = mdl[ma(a + 32'(k))];
        return r;
    endfunction

    task automatic run_mem(input bit we, input logic [1:0] len, input logic [31:0] addr,
                           input logic [31:0] wd, input bit also_if, input logic [31:0] faddr);
        int n, dc, bsel;
        logic [31:0] exp_rd;
        logic [AW-1:0] ea;
        logic ew, es;
        logic [7:0] ed;
        n      = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
        dc     = we ? n + 1 : n + 2;
        exp_rd = mdl_read(addr, n);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wd;
        if (also_if) begin if_req = 1'b1; if_addr = faddr; end
        for (int cyc = 0; cyc <= dc; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            bsel = (cyc >= 1) ? cyc - 1 : 0;
            ea = (cyc >= 1 && cyc <= n) ? ma(addr + 32'(bsel)) : '0;
            ew = we && cyc >= 1 && cyc <= n;
            ed = ew ? wd[8*bsel +: 8] : 8'h00;
            checks++;
            if ({ram_a, ram_wr, ram_dout} !== {ea, ew, ed}) begin
                failures++;
                $display("FAIL mem_ram_port cyc=%0d got a=%h wr=%b d=%h want a=%h wr=%b d=%h",
                         cyc, ram_a, ram_wr, ram_dout, ea, ew, ed);
            end
            checks++;
            if ({mem_done, if_done} !== {(cyc == dc), 1'b0}) begin
                failures++;
                $display("FAIL mem_done cyc=%0d got mem_done=%b if_done=%b want mem_done=%b",
                         cyc, mem_done, if_done, (cyc == dc));
            end
            es = also_if ? 1'b1 : (cyc != dc);
            checks++;
            if (stallreq !== es) begin
                failures++;
                $display("FAIL mem_stall cyc=%0d got %b want %b", cyc, stallreq, es);
            end
            if (cyc == dc) begin
                if (!we) begin
                    last_rdata = exp_rd;
                    checks++;
                    if (mem_rdata !== exp_rd) begin
                        failures++;
                        $display("FAIL mem_rdata addr=%h len=%0d got %h want %h", addr, len, mem_rdata, exp_rd);
                    end
                end else begin
                    for (int k = 0; k < n; k++) mdl[ma(addr + 32'(k))] = wd[8*k +: 8];
                end
            end
        end
        @(negedge clk);
        mem_req = 1'b0;
        #1;
        checks++;
        if ({mem_done, mem_rdata, ram_a, ram_wr} !== {1'b0, last_rdata, {AW{1'b0}}, 1'b0}) begin
            failures++;
            $display("FAIL mem_after_done got done=%b rdata=%h a=%h wr=%b want 0 %h 0 0",
                     mem_done, mem_rdata, ram_a, ram_wr, last_rdata);
        end
    endtask

    task automatic run_fetch(input logic [31:0] addr, input bit skip_wait, input int br_cyc);
        logic [31:0] exp;
        logic [AW-1:0] ea;
        logic ed, es;
        int last;
        exp  = mdl_read(addr, 4);
        last = (br_cyc >= 0) ? br_cyc + 1 : 6;
        if (!skip_wait) @(negedge clk);
        if_req = 1'b1; if_addr = addr; branch_flag_i = 1'b0;
        for (int cyc = 0; cyc <= last; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (cyc == br_cyc) branch_flag_i = 1'b1;
            if (br_cyc >= 0 && cyc == br_cyc + 1) begin branch_flag_i = 1'b0; if_req = 1'b0; end
            #1;
            ea = (cyc >= 1 && cyc <= 4 && (br_cyc < 0 || cyc <= br_cyc)) ? ma(addr + 32'(cyc - 1)) : '0;
            ed = (br_cyc < 0 && cyc == 6);
            checks++;
            if ({ram_a, ram_wr} !== {ea, 1'b0}) begin
                failures++;
                $display("FAIL fetch_addr cyc=%0d got a=%h wr=%b want a=%h wr=0", cyc, ram_a, ram_wr, ea);
            end
            checks++;
            if ({if_done, mem_done} !== {ed, 1'b0}) begin
                failures++;
                $display("FAIL fetch_done cyc=%0d got %b want %b", cyc, if_done, ed);
            end
            es = ed ? 1'b0 : (if_req & ~branch_flag_i);
            checks++;
            if (stallreq !== es) begin
                failures++;
                $display("FAIL fetch_stall cyc=%0d got %b want %b", cyc, stallreq, es);
            end
            if (ed) begin
                last_inst = exp;
                checks++;
                if (if_inst !== exp) begin
                    failures++;
                    $display("FAIL if_inst addr=%h got %h want %h", addr, if_inst, exp);
                end
            end
        end
        if (br_cyc >= 0) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                #1;
                checks++;
                if ({if_done, ram_a, if_inst} !== {1'b0, {AW{1'b0}}, last_inst}) begin
                    failures++;
                    $display("FAIL branch_cancel got done=%b a=%h inst=%h want 0 0 %h",
                             if_done, ram_a, if_inst, last_inst);
                end
            end
        end else begin
            @(negedge clk);
            if_req = 1'b0;
            #1;
            checks++;
            if ({if_done, if_inst} !== {1'b0, last_inst}) begin
                failures++;
                $display("FAIL fetch_hold got done=%b inst=%h want 0 %h", if_done, if_inst, last_inst);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if_req = 0; branch_flag_i = 0; mem_req = 0; mem_we = 0; mem_len = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({if_done, mem_done, if_inst, mem_rdata, ram_a, ram_wr, ram_dout, stallreq} !== '0) begin
            failures++;
            $display("FAIL reset_state got done=%b/%b inst=%h rdata=%h a=%h wr=%b d=%h stall=%b want all 0",
                     if_done, mem_done, if_inst, mem_rdata, ram_a, ram_wr, ram_dout, stallreq);
        end
        last_inst = '0; last_rdata = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fetch();
        mdl[17'h100] = 8'h13; mdl[17'h101] = 8'h05; mdl[17'h102] = 8'h00; mdl[17'h103] = 8'h00;
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'h00; ram[17'h103] = 8'h00;
        run_fetch(32'h100, 1'b0, -1);
        checks++;
        if (last_inst !== 32'h0000_0513) begin
            failures++;
            $display("FAIL fetch_known got %h want 00000513", last_inst);
        end
    endtask

    task automatic test_byte_load();
        mdl[17'h2001] = 8'hF0; ram[17'h2001] = 8'hF0;
        run_mem(1'b0, 2'd0, 32'h2001, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_word_store();
        run_mem(1'b1, 2'd2, 32'h30, 32'hDEADBEEF, 1'b0, 32'h0);
        checks++;
        if ({ram[17'h33], ram[17'h32], ram[17'h31], ram[17'h30]} !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL store_ram got %h%h%h%h want deadbeef", ram[17'h33], ram[17'h32], ram[17'h31], ram[17'h30]);
        end
        run_mem(1'b0, 2'd2, 32'h30, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_contention();
        run_mem(1'b0, 2'd1, 32'h40, 32'h0, 1'b1, 32'h104);
        run_fetch(32'h104, 1'b1, -1);
    endtask

    task automatic test_branch();
        run_fetch(32'h180, 1'b0, 3);
        run_fetch(32'h200, 1'b0, -1);
        run_fetch(32'h300, 1'b0, 5);
        run_fetch(32'h304, 1'b0, -1);
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd, exp_ram;
        wd = $urandom;
        exp_ram = {mdl[17'h503], mdl[17'h502], wd[15:8], wd[7:0]};
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = wd;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({ram_a, ram_wr, ram_dout, mem_done, if_done, mem_rdata, if_inst} !== '0) begin
            failures++;
            $display("FAIL reset_async got a=%h wr=%b d=%h done=%b/%b rdata=%h inst=%h want all 0",
                     ram_a, ram_wr, ram_dout, mem_done, if_done, mem_rdata, if_inst);
        end
        mem_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500]} !== exp_ram) begin
            failures++;
            $display("FAIL reset_partial got %h%h%h%h want %h",
                     ram[17'h503], ram[17'h502], ram[17'h501], ram[17'h500], exp_ram);
        end
        mdl[17'h500] = wd[7:0]; mdl[17'h501] = wd[15:8];
        last_inst = '0; last_rdata = '0;
        rst = 1'b1;
        run_mem(1'b0, 2'd0, 32'h502, 32'h0, 1'b0, 32'h0);
        run_mem(1'b0, 2'd1, 32'h500, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a = {a[31:AW], {(AW-2){1'b1}}, a[1:0]};
            if ($urandom_range(0, 3) == 0) run_fetch(a, 1'b0, -1);
            else run_mem(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom, 1'b0, 32'h0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < RAM_SIZE; i++) begin
            mdl[i] = 8'($urandom);
            ram[i] = mdl[i];
        end
        test_reset();
        test_fetch();
        test_byte_load();
        test_word_store();
        test_contention();
        test_branch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
- Sequences the single byte-wide RAM port shared by instruction fetch (IF) and the load/store stage (MEM).
- Serialises multi-byte accesses into per-byte RAM cycles and assembles results.
- Drives the stall request that freezes the IF/ID and later pipeline registers while an access is pending.
- Sits between the pipeline front/back stages and the RAM; MEM has priority over IF.

Parameters:
RAM_ADDR_WIDTH, 17, width of ram_a; byte address = low RAM_ADDR_WIDTH bits of (base + k).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-low.
if_req  in  1  fetch request, held until if_done.
if_addr  in  32  fetch byte address; always a 4-byte read.
branch_flag_i  in  1  taken branch; cancels an in-flight fetch.
mem_req  in  1  load/store request, held until mem_done.
mem_we  in  1  1 = store, 0 = load.
mem_len  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 treated as 4.
mem_addr  in  32  load/store base byte address; unaligned allowed.
mem_wdata  in  32  store data; byte k = bits [8k+7:8k].
ram_din  in  8  RAM read data; 1-cycle latency after ram_a.
ram_a  out  RAM_ADDR_WIDTH  RAM byte address.
ram_dout  out  8  RAM write data.
ram_wr  out  1  RAM write strobe.
if_inst  out  32  fetched instruction, little-endian; valid while if_done.
if_done  out  1  one-cycle fetch completion pulse.
mem_rdata  out  32  load data, zero-extended; valid while mem_done.
mem_done  out  1  one-cycle load/store completion pulse.
stallreq  out  1  pipeline stall request.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cnt=0; base, len and capture registers cleared.
  - if_inst, mem_rdata, if_done, mem_done = 0.
  - An in-progress access is truncated; already-written bytes remain in RAM.
- States: IDLE, IF_RD, MEM_RD, MEM_WR. cnt is 3 bits; N = byte count (1/2/4; IF always 4).
- IDLE:
  - No new access is accepted in a cycle where if_done or mem_done is high (requester still holds req).
  - Otherwise mem_req wins: latch mem_addr, len and wdata, set cnt=0, go to MEM_WR if mem_we else MEM_RD.
  - Else if if_req and !branch_flag_i: latch if_addr, cnt=0, go to IF_RD.
  - Outputs: ram_a=0, ram_wr=0, ram_dout=0.
- Read states (IF_RD / MEM_RD), combinational outputs:
  - ram_a = base+cnt while cnt<N, else 0; ram_wr=0.
- Read states, at each edge:
  - If cnt>=1, ram_din is stored to byte lane cnt-1; cnt increments.
  - When cnt==N (last byte captured): next state is IDLE and the done pulse is registered for the following cycle.
  - Word read: request seen in cycle 0, RAM cycles 1..5, done in cycle 6.
- MEM_WR:
  - While cnt<N: ram_a=base+cnt, ram_dout=wdata byte cnt, ram_wr=1.
  - When cnt==N-1, next state is IDLE; mem_done goes high the cycle after the last write.
  - Word store: request in cycle 0, writes in cycles 1..4, done in cycle 5.
- Unused upper bytes of mem_rdata are 0; sign extension is done by the MEM stage.
- Done outputs:
  - if_done and mem_done are high for exactly one cycle.
  - if_inst and mem_rdata hold their value until the next completion of the same kind.
- Branch cancel:
  - branch_flag_i=1 in any IF_RD cycle: next state is IDLE, cnt=0, and no if_done for that fetch, including when branch coincides with the final capture.
  - Branch in the done cycle does not suppress if_done; IF/ID flushes it.
  - Branch never affects MEM_RD/MEM_WR.
- stallreq (combinational) = (mem_req & !mem_done) | (if_req & !if_done & !branch_flag_i).
- Address arithmetic: base+cnt is a 32-bit add truncated to RAM_ADDR_WIDTH, wrapping at the top of RAM.
- Simultaneous if_req and mem_req in IDLE: MEM is served first; IF starts in the IDLE cycle following mem_done.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_a steps 0x100..0x103 in cycles 1-4; if_done in cycle 6 with if_inst=0x00000513.
- Byte load: mem_req, mem_we=0, mem_len=0, mem_addr=0x2001, RAM=0xF0 -> mem_done in cycle 3, mem_rdata=0x000000F0.
- Word store: mem_we=1, mem_len=2, mem_addr=0x30, mem_wdata=0xDEADBEEF -> ram_wr=1 in cycles 1-4 with (0x30,EF), (0x31,BE), (0x32,AD), (0x33,DE); mem_done in cycle 5; stallreq low in cycle 5.
- Contention: if_req and mem_req (half load at 0x40) rise together -> MEM served first, mem_done in cycle 4; fetch addresses appear starting cycle 6; if_done in cycle 11.
- Branch abort: fetch in progress, branch_flag_i=1 at cnt=2 -> IDLE next cycle, ram_a=0, no if_done; a new if_req to 0x200 is then fetched correctly.
- Async reset during a word store after 2 bytes written -> outputs 0 immediately; RAM holds only bytes 0-1; after release, a fresh byte load completes normally.
